// File: rtl/write_addr_arbiter.sv
// Two-master AXI4 write-address arbiter: round-robin AW grant, then holds W routing until wlast.
// Optional macro WR_ARB_QOS_PRIORITY_EN: strictly higher awqos wins, round-robin on ties.
module write_addr_arbiter #(
  parameter int Num_OF_Masters  = 2,
  parameter int Masters_ID_Size = $clog2(Num_OF_Masters),
  parameter int Address_width   = 32,
  parameter int AXI4_Aw_len     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       S00_AXI_awvalid,
  input  logic [Address_width-1:0]   S00_AXI_awaddr,
  input  logic [AXI4_Aw_len-1:0]     S00_AXI_awlen,
  input  logic [2:0]                 S00_AXI_awsize,
  input  logic [1:0]                 S00_AXI_awburst,
  input  logic [1:0]                 S00_AXI_awlock,
  input  logic [3:0]                 S00_AXI_awcache,
  input  logic [2:0]                 S00_AXI_awprot,
  input  logic [3:0]                 S00_AXI_awqos,
  output logic                       S00_AXI_awready,
  input  logic                       S01_AXI_awvalid,
  input  logic [Address_width-1:0]   S01_AXI_awaddr,
  input  logic [AXI4_Aw_len-1:0]     S01_AXI_awlen,
  input  logic [2:0]                 S01_AXI_awsize,
  input  logic [1:0]                 S01_AXI_awburst,
  input  logic [1:0]                 S01_AXI_awlock,
  input  logic [3:0]                 S01_AXI_awcache,
  input  logic [2:0]                 S01_AXI_awprot,
  input  logic [3:0]                 S01_AXI_awqos,
  output logic                       S01_AXI_awready,
  output logic [Masters_ID_Size-1:0] Master_AXI_awaddr_ID,
  output logic [Address_width-1:0]   Master_AXI_awaddr,
  output logic [AXI4_Aw_len-1:0]     Master_AXI_awlen,
  output logic [2:0]                 Master_AXI_awsize,
  output logic [1:0]                 Master_AXI_awburst,
  output logic [1:0]                 Master_AXI_awlock,
  output logic [3:0]                 Master_AXI_awcache,
  output logic [2:0]                 Master_AXI_awprot,
  output logic [3:0]                 Master_AXI_awqos,
  output logic                       Master_AXI_awvalid,
  input  logic                       Sel_Slave_Ready,
  input  logic                       W_Beat_Accept,
  input  logic                       W_Beat_Last,
  output logic [Masters_ID_Size-1:0] W_Sel,
  output logic                       W_Sel_Valid,
  output logic                       Burst_Len_Err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  typedef struct packed {
    logic [Address_width-1:0] addr;
    logic [AXI4_Aw_len-1:0]   len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic [1:0]               lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
  } aw_pl_t;

  localparam logic [Masters_ID_Size-1:0] ID_ONE = Masters_ID_Size'(1);

  state_t                            state;
  logic [Masters_ID_Size-1:0]        grant, last_srv, win;
  logic [AXI4_Aw_len-1:0]            beat_cnt;
  logic                              len_err;
  logic [Num_OF_Masters-1:0]         req, rdy;
  aw_pl_t [Num_OF_Masters-1:0]       pl;
  aw_pl_t                            out_pl;

  assign req   = {S01_AXI_awvalid, S00_AXI_awvalid};
  assign pl[0] = {S00_AXI_awaddr, S00_AXI_awlen, S00_AXI_awsize, S00_AXI_awburst,
                  S00_AXI_awlock, S00_AXI_awcache, S00_AXI_awprot, S00_AXI_awqos};
  assign pl[1] = {S01_AXI_awaddr, S01_AXI_awlen, S01_AXI_awsize, S01_AXI_awburst,
                  S01_AXI_awlock, S01_AXI_awcache, S01_AXI_awprot, S01_AXI_awqos};

  // On a tie the master that was not served last wins; a lone requester always wins.
  always_comb begin
    if (req[0] && req[1]) win = (last_srv == '0) ? ID_ONE : '0;
    else                  win = req[0] ? '0 : ID_ONE;
`ifdef WR_ARB_QOS_PRIORITY_EN
    if (req[0] && req[1]) begin
      if (pl[0].qos > pl[1].qos)      win = '0;
      else if (pl[1].qos > pl[0].qos) win = ID_ONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      last_srv <= ID_ONE;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          grant <= win;
          state <= ADDR;
        end
        ADDR: begin
          // Withdrawn request: drop the grant without counting it as served.
          if (!req[grant]) state <= IDLE;
          else if (Sel_Slave_Ready) begin
            beat_cnt <= pl[grant].len;
            last_srv <= grant;
            state    <= DATA;
          end
        end
        DATA: if (W_Beat_Accept) begin
          beat_cnt <= (beat_cnt == '0) ? '0 : beat_cnt - AXI4_Aw_len'(1);
          len_err  <= W_Beat_Last ? (beat_cnt != '0) : (beat_cnt == '0);
          if (W_Beat_Last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Master_AXI_awvalid   = 1'b0;
    Master_AXI_awaddr_ID = '0;
    out_pl               = '0;
    rdy                  = '0;
    if (state == ADDR) begin
      Master_AXI_awvalid   = req[grant];
      Master_AXI_awaddr_ID = grant;
      out_pl               = pl[grant];
      rdy[grant]           = Sel_Slave_Ready;
    end
  end

  assign S00_AXI_awready    = rdy[0];
  assign S01_AXI_awready    = rdy[1];
  assign Master_AXI_awaddr  = out_pl.addr;
  assign Master_AXI_awlen   = out_pl.len;
  assign Master_AXI_awsize  = out_pl.size;
  assign Master_AXI_awburst = out_pl.burst;
  assign Master_AXI_awlock  = out_pl.lock;
  assign Master_AXI_awcache = out_pl.cache;
  assign Master_AXI_awprot  = out_pl.prot;
  assign Master_AXI_awqos   = out_pl.qos;

  assign W_Sel_Valid   = (state == DATA);
  assign W_Sel         = (state == DATA) ? grant : '0;
  assign Burst_Len_Err = len_err;

endmodule
